// File: rtl/seqdet_ctrl_pkg.sv
// Shared definitions for the sequence-detector stream controller:
// controller state encoding and default sizing.
package seqdet_ctrl_pkg;

    localparam int DATA_W_DEF    = 24;
    localparam int LEN_W_DEF     = 5;
    localparam int CNT_W_DEF     = 8;
    localparam int DRAIN_CYC_DEF = 2;
    localparam int REPS_W        = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_SHIFT,
        ST_DRAIN,
        ST_DONE
    } state_t;

endpackage

// File: rtl/seqdet_pat_shifter.sv
// Pattern store, MSB-first shift register, bit index and pass counter.
// Optional macro SEQDET_FIRST_HIT_EN adds position outputs used for
// first-hit capture in the top.
module seqdet_pat_shifter
    import seqdet_ctrl_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int LEN_W  = LEN_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [DATA_W-1:0] pattern_in,
    input  logic [LEN_W-1:0]  len_in,
    input  logic [REPS_W-1:0] reps_in,
    input  logic              clear,
    input  logic              shift_en,
    output logic              x_bit,
    output logic [LEN_W-1:0]  bit_idx,
    output logic              last_bit,
    output logic              last_pass,
    output logic              len_zero
`ifdef SEQDET_FIRST_HIT_EN
    ,
    output logic [REPS_W-1:0] pass_idx,
    output logic [REPS_W-1:0] pass_last_idx,
    output logic [LEN_W-1:0]  len_last
`endif
);

    logic [DATA_W-1:0] pat_q, pat_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [REPS_W-1:0] reps_q, reps_d;
    logic [DATA_W-1:0] shreg_q, shreg_d;
    logic [LEN_W-1:0]  idx_q, idx_d;
    logic [REPS_W-1:0] rep_cnt_q, rep_cnt_d;

    assign x_bit     = shreg_q[DATA_W-1];
    assign bit_idx   = idx_q;
    assign last_bit  = (idx_q == len_q - 1'b1);
    assign last_pass = (rep_cnt_q == REPS_W'(1));
    assign len_zero  = (len_q == '0);

`ifdef SEQDET_FIRST_HIT_EN
    assign pass_idx      = reps_q - rep_cnt_q;
    assign pass_last_idx = reps_q - 1'b1;
    assign len_last      = len_q - 1'b1;
`endif

    // Capture configuration on load; on clear prime a run; while shifting
    // advance one bit and restart at the MSB at the end of each pass.
    always_comb begin
        pat_d     = pat_q;
        len_d     = len_q;
        reps_d    = reps_q;
        shreg_d   = shreg_q;
        idx_d     = idx_q;
        rep_cnt_d = rep_cnt_q;
        if (load) begin
            pat_d  = pattern_in;
            len_d  = (len_in > LEN_W'(DATA_W)) ? LEN_W'(DATA_W) : len_in;
            reps_d = (reps_in == '0) ? REPS_W'(1) : reps_in;
        end
        if (clear) begin
            shreg_d   = pat_q;
            idx_d     = '0;
            rep_cnt_d = reps_q;
        end else if (shift_en) begin
            if (last_bit) begin
                shreg_d   = pat_q;
                idx_d     = '0;
                rep_cnt_d = rep_cnt_q - 1'b1;
            end else begin
                shreg_d = {shreg_q[DATA_W-2:0], 1'b0};
                idx_d   = idx_q + 1'b1;
            end
        end
    end

    // State registers with synchronous reset to an empty one-pass config.
    always_ff @(posedge clk) begin
        if (rst) begin
            pat_q     <= '0;
            len_q     <= '0;
            reps_q    <= REPS_W'(1);
            shreg_q   <= '0;
            idx_q     <= '0;
            rep_cnt_q <= REPS_W'(1);
        end else begin
            pat_q     <= pat_d;
            len_q     <= len_d;
            reps_q    <= reps_d;
            shreg_q   <= shreg_d;
            idx_q     <= idx_d;
            rep_cnt_q <= rep_cnt_d;
        end
    end

endmodule

// File: rtl/seqdet_stream_ctrl.sv
// Stream controller for a serial sequence detector: clears the detector,
// streams the stored pattern MSB-first for len bits x reps passes, drains,
// and counts det_z hits (saturating).
// Optional macro SEQDET_FIRST_HIT_EN adds first_hit_pos / first_hit_vld.
module seqdet_stream_ctrl
    import seqdet_ctrl_pkg::*;
#(
    parameter int DATA_W    = DATA_W_DEF,
    parameter int LEN_W     = LEN_W_DEF,
    parameter int CNT_W     = CNT_W_DEF,
    parameter int DRAIN_CYC = DRAIN_CYC_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [DATA_W-1:0] pattern_in,
    input  logic [LEN_W-1:0]  len_in,
    input  logic [REPS_W-1:0] reps_in,
    input  logic              start,
    input  logic              det_z,
    output logic              x_out,
    output logic              det_clr,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  hit_count,
    output logic [LEN_W-1:0]  bit_idx
`ifdef SEQDET_FIRST_HIT_EN
    ,
    output logic [LEN_W+4-1:0] first_hit_pos,
    output logic               first_hit_vld
`endif
);

    localparam int DRN_W = $clog2(DRAIN_CYC + 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] hit_q, hit_d;
    logic [DRN_W-1:0] drain_q, drain_d;

    logic x_bit, last_bit, last_pass, len_zero;
    logic load_acc, counting;

    assign load_acc = load && (state_q == ST_IDLE);
    assign counting = (state_q == ST_SHIFT) || (state_q == ST_DRAIN);

`ifdef SEQDET_FIRST_HIT_EN
    logic [REPS_W-1:0]  pass_idx, pass_last_idx;
    logic [LEN_W-1:0]   len_last;
    logic [LEN_W+3:0]   fh_pos_q, fh_pos_d;
    logic               fh_vld_q, fh_vld_d;
`endif

    seqdet_pat_shifter #(
        .DATA_W (DATA_W),
        .LEN_W  (LEN_W)
    ) u_shifter (
        .clk        (clk),
        .rst        (rst),
        .load       (load_acc),
        .pattern_in (pattern_in),
        .len_in     (len_in),
        .reps_in    (reps_in),
        .clear      (state_q == ST_CLEAR),
        .shift_en   (state_q == ST_SHIFT),
        .x_bit      (x_bit),
        .bit_idx    (bit_idx),
        .last_bit   (last_bit),
        .last_pass  (last_pass),
        .len_zero   (len_zero)
`ifdef SEQDET_FIRST_HIT_EN
        ,
        .pass_idx      (pass_idx),
        .pass_last_idx (pass_last_idx),
        .len_last      (len_last)
`endif
    );

    // Next-state, drain timing and saturating hit counter.
    always_comb begin
        state_d = state_q;
        hit_d   = hit_q;
        drain_d = drain_q;
        case (state_q)
            ST_IDLE: begin
                // A simultaneous load wins; start is dropped that cycle.
                if (start && !load) begin
                    hit_d   = '0;
                    state_d = len_zero ? ST_DONE : ST_CLEAR;
                end
            end
            ST_CLEAR: state_d = ST_SHIFT;
            ST_SHIFT: begin
                if (last_bit && last_pass) begin
                    state_d = ST_DRAIN;
                    drain_d = '0;
                end
            end
            ST_DRAIN: begin
                if (drain_q == DRN_W'(DRAIN_CYC - 1)) begin
                    state_d = ST_DONE;
                end else begin
                    drain_d = drain_q + 1'b1;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        if (counting && det_z && (hit_q != '1)) begin
            hit_d = hit_q + 1'b1;
        end
    end

    // Controller registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            hit_q   <= '0;
            drain_q <= '0;
        end else begin
            state_q <= state_d;
            hit_q   <= hit_d;
            drain_q <= drain_d;
        end
    end

    assign x_out     = (state_q == ST_SHIFT) ? x_bit : 1'b0;
    assign det_clr   = (state_q == ST_CLEAR);
    assign busy      = (state_q == ST_CLEAR) || counting;
    assign done      = (state_q == ST_DONE);
    assign hit_count = hit_q;

`ifdef SEQDET_FIRST_HIT_EN
    // Record where the first hit of a run landed; drain hits map to the
    // final bit of the final pass.
    always_comb begin
        fh_pos_d = fh_pos_q;
        fh_vld_d = fh_vld_q;
        if (state_q == ST_CLEAR) begin
            fh_pos_d = '0;
            fh_vld_d = 1'b0;
        end else if (det_z && !fh_vld_q) begin
            if (state_q == ST_SHIFT) begin
                fh_pos_d = {pass_idx, bit_idx};
                fh_vld_d = 1'b1;
            end else if (state_q == ST_DRAIN) begin
                fh_pos_d = {pass_last_idx, len_last};
                fh_vld_d = 1'b1;
            end
        end
    end

    // First-hit registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            fh_pos_q <= '0;
            fh_vld_q <= 1'b0;
        end else begin
            fh_pos_q <= fh_pos_d;
            fh_vld_q <= fh_vld_d;
        end
    end

    assign first_hit_pos = fh_pos_q;
    assign first_hit_vld = fh_vld_q;
`endif

endmodule
